// File: rtl/ram_dp_clr.sv
// Purpose: dual-port RAM (port A read/write, port B read-only) with optional zero-fill after reset.
// Latency: 1 cycle on both read ports; clear sweep takes 2**ADDR_BITS cycles after reset.
// Backpressure: none in READY (one request per port per cycle); busy=1 while clearing, requests dropped.
//
// Ports:
//   clk, rst          sole clock, synchronous active-high reset
//   we, addr_a, di    port A write enable / address / write data
//   dout_a            port A registered read data (every READY cycle)
//   re_b, addr_b      port B read request / address
//   dout_b, valid_b   port B registered read data and its valid flag
//   busy              clear sweep in progress
module ram_dp_clr #(
  parameter int WIDTH          = 8,
  parameter int ADDR_BITS      = 13,
  parameter bit RDW_NEW        = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr_a,
  input  logic [WIDTH-1:0]     di,
  output logic [WIDTH-1:0]     dout_a,
  input  logic                 re_b,
  input  logic [ADDR_BITS-1:0] addr_b,
  output logic [WIDTH-1:0]     dout_b,
  output logic                 valid_b,
  output logic                 busy
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Counter is one bit wider than the address so it cannot wrap mid-sweep.
  localparam logic [ADDR_BITS:0] CNT_LAST = (ADDR_BITS+1)'(DEPTH - 1);
  localparam logic [ADDR_BITS:0] CNT_ONE  = (ADDR_BITS+1)'(1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t               state;
  logic [ADDR_BITS:0]   clr_cnt;
  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [WIDTH-1:0]     mem_wdat;

  // Single write port shared between the clear sweep and user port A.
  // No write happens on a reset edge; the sweep restarts from address 0.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_a;
    mem_wdat  = di;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt[ADDR_BITS-1:0];
        mem_wdat  = '0;
      end else if (we) begin
        mem_we = 1'b1;
      end
    end
  end

  // Array kept free of reset so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? CLEAR : READY;
      busy    <= CLEAR_ON_RESET;
      clr_cnt <= '0;
      dout_a  <= '0;
      dout_b  <= '0;
      valid_b <= 1'b0;
    end else if (state == CLEAR) begin
      // Read outputs hold; port requests are ignored.
      valid_b <= 1'b0;
      clr_cnt <= clr_cnt + CNT_ONE;
      if (clr_cnt == CNT_LAST) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end else begin
      // Port A reads every cycle. Array read sees pre-write contents,
      // so bypass di only when new-data read-during-write is selected.
      dout_a <= (RDW_NEW && we) ? di : mem[addr_a];
      // Port B never bypasses: a same-address write returns old data.
      if (re_b) begin
        dout_b  <= mem[addr_b];
        valid_b <= 1'b1;
      end else begin
        valid_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Purpose: directed bench for ram_dp_clr with ADDR_BITS=4, WIDTH=8.
// Three instances share stimulus: new-data RDW, old-data RDW, and no clear on reset.
// Outputs are sampled 1 time unit after the rising edge that produced them.
module tb_ram_dp_clr;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [3:0] addr_a;
  logic [7:0] di;
  logic       re_b;
  logic [3:0] addr_b;

  logic [7:0] dout_a_new, dout_b_new, dout_a_old, dout_b_old, dout_a_nc, dout_b_nc;
  logic       valid_b_new, busy_new, valid_b_old, busy_old, valid_b_nc, busy_nc;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ram_dp_clr #(.WIDTH(8), .ADDR_BITS(4), .RDW_NEW(1'b1), .CLEAR_ON_RESET(1'b1)) u_new (
    .clk(clk), .rst(rst), .we(we), .addr_a(addr_a), .di(di), .dout_a(dout_a_new),
    .re_b(re_b), .addr_b(addr_b), .dout_b(dout_b_new), .valid_b(valid_b_new), .busy(busy_new)
  );

  ram_dp_clr #(.WIDTH(8), .ADDR_BITS(4), .RDW_NEW(1'b0), .CLEAR_ON_RESET(1'b1)) u_old (
    .clk(clk), .rst(rst), .we(we), .addr_a(addr_a), .di(di), .dout_a(dout_a_old),
    .re_b(re_b), .addr_b(addr_b), .dout_b(dout_b_old), .valid_b(valid_b_old), .busy(busy_old)
  );

  ram_dp_clr #(.WIDTH(8), .ADDR_BITS(4), .RDW_NEW(1'b1), .CLEAR_ON_RESET(1'b0)) u_nc (
    .clk(clk), .rst(rst), .we(we), .addr_a(addr_a), .di(di), .dout_a(dout_a_nc),
    .re_b(re_b), .addr_b(addr_b), .dout_b(dout_b_nc), .valid_b(valid_b_nc), .busy(busy_nc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy=1 on u_new (bounded) and records any valid_b seen meanwhile.
  task automatic count_busy(output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!busy_new) break;
      if (valid_b_new || valid_b_old) saw_valid = 1'b1;
      n++;
      step();
    end
  endtask

  initial begin
    int  nb;
    bit  sv;
    bit  clr_busy_ok;

    rst = 1'b1; we = 1'b0; addr_a = '0; di = '0; re_b = 1'b0; addr_b = '0;
    #2;
    step();
    // Reset values on the first rst edge.
    check("rst_busy",     32'(busy_new),    32'd1);
    check("rst_dout_a",   32'(dout_a_new),  32'h00);
    check("rst_dout_b",   32'(dout_b_new),  32'h00);
    check("rst_valid_b",  32'(valid_b_new), 32'd0);
    check("rst_busy_nc",  32'(busy_nc),     32'd0);
    rst = 1'b0;

    // Clean clear sweep: exactly 16 busy cycles.
    count_busy(nb, sv);
    check("clear_cycles", 32'(nb), 32'd16);
    check("busy_old_low", 32'(busy_old), 32'd0);

    // Port B sweep over the cleared array.
    for (int i = 0; i < 16; i++) begin
      re_b = 1'b1; addr_b = 4'(i);
      step();
      check($sformatf("sweep_vld_%0d", i), 32'(valid_b_new), 32'd1);
      check($sformatf("sweep_dat_%0d", i), 32'(dout_b_new),  32'h00);
    end
    re_b = 1'b0;

    // Read-during-write on port A.
    we = 1'b1; addr_a = 4'd3; di = 8'h11;
    step();
    di = 8'hA5;
    step();
    check("rdw_new",    32'(dout_a_new), 32'hA5);
    check("rdw_old",    32'(dout_a_old), 32'h11);
    check("rdw_new_nc", 32'(dout_a_nc),  32'hA5);
    we = 1'b0;
    step();
    check("rd_after_new", 32'(dout_a_new), 32'hA5);
    check("rd_after_old", 32'(dout_a_old), 32'hA5);

    // Port B reading the address port A writes in the same cycle.
    we = 1'b1; addr_a = 4'd9; di = 8'h5A; re_b = 1'b1; addr_b = 4'd9;
    step();
    check("rdw_b_dat_new", 32'(dout_b_new),  32'h00);
    check("rdw_b_dat_old", 32'(dout_b_old),  32'h00);
    check("rdw_b_vld",     32'(valid_b_new), 32'd1);
    we = 1'b0;
    step();
    check("rdw_b_next", 32'(dout_b_new), 32'h5A);

    // re_b toggling 1,0,1 over 0x22 at 2 and 0x44 at 4.
    re_b = 1'b0;
    we = 1'b1; addr_a = 4'd2; di = 8'h22;
    step();
    addr_a = 4'd4; di = 8'h44;
    step();
    we = 1'b0;
    re_b = 1'b1; addr_b = 4'd2;
    step();
    check("tog_vld_1", 32'(valid_b_new), 32'd1);
    check("tog_dat_1", 32'(dout_b_new),  32'h22);
    re_b = 1'b0; addr_b = 4'd7;
    step();
    check("tog_vld_0", 32'(valid_b_new), 32'd0);
    check("tog_dat_0", 32'(dout_b_new),  32'h22);
    re_b = 1'b1; addr_b = 4'd4;
    step();
    check("tog_vld_2", 32'(valid_b_new), 32'd1);
    check("tog_dat_2", 32'(dout_b_new),  32'h44);
    re_b = 1'b0;

    // Reset, then re-assert at clear cycle 7 with requests pending throughout.
    rst = 1'b1;
    step();
    rst = 1'b0;
    we = 1'b1; addr_a = 4'd6; di = 8'hFF; re_b = 1'b1; addr_b = 4'd6;
    clr_busy_ok = 1'b1;
    sv = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (!busy_new) clr_busy_ok = 1'b0;
      if (valid_b_new) sv = 1'b1;
      step();
    end
    check("busy_pre_restart", 32'(clr_busy_ok), 32'd1);
    rst = 1'b1;
    step();
    check("busy_at_restart", 32'(busy_new), 32'd1);
    rst = 1'b0;
    begin
      bit sv2;
      count_busy(nb, sv2);
      sv = sv | sv2;
    end
    we = 1'b0; re_b = 1'b0;
    check("restart_cycles",   32'(nb), 32'd16);
    check("busy_valid_never", 32'(sv), 32'd0);

    // Requests made during busy must not have written; old data is cleared.
    re_b = 1'b1; addr_b = 4'd6; addr_a = 4'd2;
    step();
    check("post_clr_b6",  32'(dout_b_new), 32'h00);
    check("post_clr_vld", 32'(valid_b_new), 32'd1);
    check("post_clr_a2",  32'(dout_a_new), 32'h00);
    addr_b = 4'd9; addr_a = 4'd3;
    step();
    check("post_clr_b9",  32'(dout_b_new), 32'h00);
    check("post_clr_a3",  32'(dout_a_old), 32'h00);
    re_b = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 13, address width; depth = 2**ADDR_BITS words.
REQ-003 SHALL have parameter RDW_NEW, default 1; 1 = port A read-during-write returns new data, 0 = returns old data.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero entire array after reset, 0 = no clear.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 we  input  1  port A write enable.
REQ-008 addr_a  input  ADDR_BITS  port A read/write address.
REQ-009 di  input  WIDTH  port A write data.
REQ-010 dout_a  output  WIDTH  port A registered read data.
REQ-011 re_b  input  1  port B read request.
REQ-012 addr_b  input  ADDR_BITS  port B read-only address.
REQ-013 dout_b  output  WIDTH  port B registered read data.
REQ-014 valid_b  output  1  dout_b holds data for the re_b accepted in the previous cycle.
REQ-015 busy  output  1  clear in progress; port requests ignored.

Function
REQ-016 SHALL implement an FSM with states CLEAR and READY.
REQ-017 On a rising edge with rst=1: state CLEAR if CLEAR_ON_RESET=1, else READY; clear counter to 0; dout_a, dout_b, valid_b to 0.
REQ-018 In CLEAR: write 0 to address = counter each cycle; counter increments by 1; after the write to address 2**ADDR_BITS-1, go to READY (clear takes exactly 2**ADDR_BITS cycles).
REQ-019 busy SHALL be 1 exactly while state = CLEAR; it is a registered output.
REQ-020 While busy=1: we and re_b are ignored; no user write occurs; valid_b stays 0; dout_a and dout_b hold their values.
REQ-021 rst asserted during CLEAR SHALL restart the clear from address 0.
REQ-022 In READY with we=1: mem[addr_a] <= di on that edge.
REQ-023 Port A read latency SHALL be 1 cycle: dout_a <= mem[addr_a] every READY cycle, whether or not we=1.
REQ-024 If we=1 and RDW_NEW=1, dout_a SHALL equal di the next cycle; if RDW_NEW=0, dout_a SHALL equal the pre-write contents.
REQ-025 In READY with re_b=1: dout_b <= mem[addr_b] and valid_b <= 1; with re_b=0: valid_b <= 0, dout_b holds.
REQ-026 If port B reads the address port A writes in the same cycle, dout_b SHALL return the old data, regardless of RDW_NEW.
REQ-027 Addresses SHALL be used modulo 2**ADDR_BITS with no out-of-range check; the clear counter width is ADDR_BITS+1 so it never wraps during a clear.
REQ-028 Back-to-back requests on both ports SHALL be accepted every cycle with no stall.

Reset
REQ-029 Reset SHALL be synchronous; outputs take reset values on the first rising edge with rst=1 and hold them while rst=1.
REQ-030 With CLEAR_ON_RESET=0, memory contents SHALL be undefined after reset, and busy SHALL be 0 from the first edge with rst=1.

Verification (ADDR_BITS=4, WIDTH=8)
REQ-031 rst 1 cycle, CLEAR_ON_RESET=1 -> busy=1 for exactly 16 cycles after rst falls; then re_b sweep of addresses 0..15 returns 0x00 each, with valid_b=1 one cycle after each request.
REQ-032 rst re-asserted at clear cycle 7 -> busy stays 1 and clear restarts; 16 busy cycles after the second rst falls.
REQ-033 RDW_NEW=1: write 0xA5 to addr_a=3 -> dout_a=0xA5 the next cycle; RDW_NEW=0 with mem[3]=0x11 -> dout_a=0x11, then 0xA5 on a following read.
REQ-034 Same-cycle write 0x5A to addr_a=9 and re_b at addr_b=9 over old data 0x00 -> dout_b=0x00 with valid_b=1; a re_b on the next cycle -> 0x5A.
REQ-035 we=1 and re_b=1 driven during busy -> memory unchanged after clear (reads 0x00) and valid_b never asserted.
REQ-036 re_b toggling 1,0,1 at addresses 2,x,4 holding 0x22/0x44 -> valid_b 1,0,1 one cycle later; dout_b 0x22, holds 0x22, then 0x44.
